dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder servicing the CPU's LW/SW accesses through a valid/ready request channel and a valid/ready response channel.
//   Holds a word-addressed data array and returns read data or a write acknowledge after a programmable number of wait states.
//   One request is outstanding at a time. Sits between the MEM stage of the pipelined CPU and the data storage.
// PARAMETERS
//   ADDR_W       10  word-address width; array depth = 2**ADDR_W words (1024)
//   DATA_W       32  data word width
//   WAIT_CYCLES  2   extra wait states between accept and response (0..15)
// PORTS
//   clock      in   1       single clock, rising edge
//   reset_n    in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       responder can accept a request
//   req_we     in   1       1 = store (SW), 0 = load (LW)
//   req_addr   in   32      byte address
//   req_wdata  in   DATA_W  store data
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       requester takes the response
//   rsp_rdata  out  DATA_W  load data (0 for stores and errors)
//   rsp_err    out  1       misaligned or out-of-range address
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   Reset (async, reset_n=0):
//   - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
//   - Array contents are not cleared. Simulation initial value is 0.
//   FSM states:
//   - IDLE: req_ready=1. On req_valid&req_ready, latch we/addr/wdata and load counter=WAIT_CYCLES.
//     Go to WAIT if WAIT_CYCLES>0, else to RESP.
//   - WAIT: req_ready=0. Counter decrements once per cycle. When counter==1, go to RESP.
//   - RESP: rsp_valid=1; rsp_rdata/rsp_err are stable while rsp_ready=0.
//     On rsp_valid&rsp_ready, return to IDLE.
//   Latency and ordering:
//   - Request accepted at edge N: rsp_valid rises after edge N+1+WAIT_CYCLES.
//   - Memory access (write commit or read sample) happens at the edge that enters RESP.
//   - A store is therefore visible to any later request.
//   - req_ready is low from the accept edge until the edge after the response handshake. There are no back-to-back accepts.
//   - req_* inputs are ignored outside the IDLE handshake. Latched values do not change mid-transaction.
//   Addressing:
//   - word index = req_addr[ADDR_W+1:2].
//   - rsp_err=1 if req_addr[1:0]!=0 or req_addr[31:ADDR_W+2]!=0.
//   - On error: no array access (a store is dropped) and rsp_rdata=0. The response still occurs with normal latency.
//   Responses:
//   - Store response: rsp_rdata=0, rsp_err per address check.
//   - After the RESP handshake, rsp_rdata and rsp_err return to 0.
//   Reset mid-operation:
//   - Transaction aborted, FSM returns to IDLE, no response is issued.
//   - A store not yet committed (still in WAIT) is discarded.
//   - A store already committed (in RESP) remains in the array.
//   Counter width: 4 bits. WAIT_CYCLES>15 is illegal; elaboration must fail.
// TESTING
//   T1 Reset: reset_n=0 mid-WAIT -> next cycle req_ready=1, rsp_valid=0, busy=0; no response ever appears for the aborted request.
//   T2 Store then load, WAIT_CYCLES=2:
//      - SW addr=0x10 data=0xDEADBEEF accepted at edge N -> rsp_valid after edge N+3, rsp_err=0.
//      - LW addr=0x10 -> rsp_rdata=0xDEADBEEF.
//   T3 Backpressure: hold rsp_ready=0 for 5 cycles ->
//      - rsp_valid, rsp_rdata, rsp_err stay stable and req_ready=0.
//      - Response consumed on the first cycle rsp_ready=1.
//      - req_ready=1 the cycle after.
//   T4 Errors:
//      - SW addr=0x13 -> rsp_err=1 and word 4 unchanged.
//      - LW addr=0x1000 (index 1024) -> rsp_err=1, rsp_rdata=0.
//   T5 Boundary: WAIT_CYCLES=0 -> response after edge N+1.
//      - SW/LW addr=0xFFC (last word) -> data 0x12345678 round-trips, rsp_err=0.
//   T6 Ignored input: req_valid toggles with new addr/data while busy -> no extra accepts; responses match the latched requests only.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed array behind valid/ready request and response channels.
// Each access is answered WAIT_CYCLES wait states after acceptance; one request in flight at a time.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  if (WAIT_CYCLES > 15) begin : g_wait_range
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  // Access result captured on the edge entering RESP, presented one cycle later.
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [Depth];

  logic              acc_fire;
  logic              acc_we;
  logic              acc_err;
  logic [31:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [ADDR_W-1:0] acc_idx;

  // With zero wait states the access uses the live request, otherwise the latched one.
  always_comb begin
    acc_fire  = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == StIdle) begin
      acc_fire  = req_valid && (WAIT_CYCLES == 0);
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else if (state_q == StWait) begin
      acc_fire = (cnt_q == 4'd1);
    end
    acc_idx = acc_addr[ADDR_W+1:2];
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_W+2] != '0);
  end

  always_ff @(posedge clock) begin
    if (reset_n && acc_fire && acc_we && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (acc_fire) begin
        data_q <= (acc_we || acc_err) ? '0 : mem[acc_idx];
        err_q  <= acc_err;
      end
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt_q     <= 4'(WAIT_CYCLES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_q   <= (WAIT_CYCLES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= data_q;
            rsp_err   <= err_q;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked every cycle against a
// transaction-level model, plus directed scenarios with literal expectations.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid [2];
  logic        req_we    [2];
  logic        rsp_ready [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic        busy      [2];
  logic [31:0] rsp_rdata [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(2)) u_dut_w2 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  function automatic int wait_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, want %h at %0t", name, d, act, exp, $time);
    end
  endfunction

  // Transaction model: one outstanding request, tracked by edges elapsed since acceptance.
  bit          m_out   [2];
  int          m_k     [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic        m_err   [2];
  bit          m_rdkn  [2];
  logic [31:0] m_mem   [2][1024];
  bit          m_known [2][1024];

  function automatic void model_commit(int d);
    int unsigned idx;
    idx = (m_addr[d] / 4) % 1024;
    m_err[d] = (m_addr[d] % 4 != 0) || (m_addr[d] >= 32'h1000);
    m_rdata[d] = 32'd0;
    m_rdkn[d] = 1'b1;
    if (!m_err[d]) begin
      if (m_we[d]) begin
        m_mem[d][idx] = m_wdata[d];
        m_known[d][idx] = 1'b1;
      end else begin
        m_rdata[d] = m_mem[d][idx];
        m_rdkn[d] = m_known[d][idx];
      end
    end
  endfunction

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      bit ev;
      int w;
      w = wait_of(d);
      if (!reset_n) m_out[d] = 1'b0;
      ev = m_out[d] && (m_k[d] >= w + 1);
      chk("req_ready", d, 32'(req_ready[d]), 32'(!m_out[d]));
      chk("busy", d, 32'(busy[d]), 32'(m_out[d]));
      chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(ev));
      chk("rsp_err", d, 32'(rsp_err[d]), ev ? 32'(m_err[d]) : 32'd0);
      if (!ev || m_rdkn[d]) chk("rsp_rdata", d, rsp_rdata[d], ev ? m_rdata[d] : 32'd0);
      if (reset_n) begin
        if (m_out[d]) begin
          if (ev && rsp_ready[d]) begin
            m_out[d] = 1'b0;
          end else begin
            m_k[d]++;
            if (m_k[d] == w) model_commit(d);
          end
        end else if (req_valid[d]) begin
          m_out[d]   = 1'b1;
          m_k[d]     = 0;
          m_we[d]    = req_we[d];
          m_addr[d]  = req_addr[d];
          m_wdata[d] = req_wdata[d];
          if (w == 0) model_commit(d);
        end
      end
    end
  end

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    int unsigned idx;
    logic [31:0] a;
    r = $urandom_range(0, 15);
    idx = (r < 10) ? $urandom_range(0, 7) : $urandom_range(1016, 1023);
    a = 32'(idx * 4);
    if (r == 13) a = a + 32'($urandom_range(1, 3));
    if (r >= 14) a = a + (32'h1000 << $urandom_range(0, 19));
    return a;
  endfunction

  // Issue one request from idle, optionally jiggle req_* while busy, then take the response.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input bit noise,
                        output logic [31:0] rdata, output logic err, output int lat);
    bit got;
    @(posedge clock); #2;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
    rsp_ready[d] = 1'b0;
    @(posedge clock); #2;
    req_valid[d] = 1'b0;
    lat = 0; got = 1'b0; rdata = 32'd0; err = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clock);
      if (rsp_valid[d]) begin
        got = 1'b1;
      end else begin
        lat++;
        @(posedge clock); #2;
        if (noise) begin
          req_valid[d] = 1'($urandom_range(0, 1));
          req_we[d]    = 1'($urandom_range(0, 1));
          req_addr[d]  = $urandom;
          req_wdata[d] = $urandom;
        end
      end
    end
    if (!got) begin
      chk("rsp_timeout", d, 32'(rsp_valid[d]), 32'd1);
      return;
    end
    @(posedge clock); #2;
    req_valid[d] = 1'b0;
    repeat (hold) begin
      @(posedge clock); #2;
    end
    rsp_ready[d] = 1'b1;
    @(negedge clock);
    rdata = rsp_rdata[d];
    err = rsp_err[d];
    @(posedge clock); #2;
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; rsp_ready[d] = 1'b0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
      chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
      chk("rst_rdata", d, rsp_rdata[d], 32'd0);
    end

    // Store then load, two wait states.
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er, lat);
    chk("t2_sw_latency", 0, 32'(lat), 32'd3);
    chk("t2_sw_err", 0, 32'(er), 32'd0);
    chk("t2_sw_rdata", 0, rd, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'd0, 0, 1'b0, rd, er, lat);
    chk("t2_lw_rdata", 0, rd, 32'hDEADBEEF);
    chk("t2_lw_err", 0, 32'(er), 32'd0);

    // Backpressure: stability is checked cycle by cycle by the model.
    do_req(0, 1'b0, 32'h10, 32'd0, 5, 1'b0, rd, er, lat);
    chk("t3_rdata", 0, rd, 32'hDEADBEEF);

    // Errors.
    do_req(0, 1'b1, 32'h13, 32'h0BADF00D, 0, 1'b0, rd, er, lat);
    chk("t4_sw_mis_err", 0, 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h10, 32'd0, 0, 1'b0, rd, er, lat);
    chk("t4_word4_kept", 0, rd, 32'hDEADBEEF);
    do_req(0, 1'b0, 32'h1000, 32'd0, 0, 1'b0, rd, er, lat);
    chk("t4_lw_oor_err", 0, 32'(er), 32'd1);
    chk("t4_lw_oor_rdata", 0, rd, 32'd0);

    // Zero wait states, last word.
    do_req(1, 1'b1, 32'hFFC, 32'h12345678, 0, 1'b0, rd, er, lat);
    chk("t5_sw_latency", 1, 32'(lat), 32'd1);
    chk("t5_sw_err", 1, 32'(er), 32'd0);
    do_req(1, 1'b0, 32'hFFC, 32'd0, 0, 1'b0, rd, er, lat);
    chk("t5_lw_rdata", 1, rd, 32'h12345678);
    chk("t5_lw_err", 1, 32'(er), 32'd0);

    // Request inputs toggling while busy.
    do_req(0, 1'b1, 32'h24, 32'hCAFEF00D, 2, 1'b1, rd, er, lat);
    do_req(0, 1'b0, 32'h24, 32'd0, 0, 1'b1, rd, er, lat);
    chk("t6_lw_rdata", 0, rd, 32'hCAFEF00D);
    do_req(1, 1'b1, 32'h8, 32'hA5A5A5A5, 3, 1'b1, rd, er, lat);
    do_req(1, 1'b0, 32'h8, 32'd0, 0, 1'b1, rd, er, lat);
    chk("t6_lw_rdata", 1, rd, 32'hA5A5A5A5);

    // Reset in the middle of a wait: the store is discarded and no response appears.
    do_req(0, 1'b1, 32'h20, 32'h11111111, 0, 1'b0, rd, er, lat);
    @(posedge clock); #2;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h22222222;
    @(posedge clock); #2;
    req_valid[0] = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b0;
    @(negedge clock);
    chk("t1_req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("t1_busy", 0, 32'(busy[0]), 32'd0);
    chk("t1_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    @(posedge clock); #2;
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    do_req(0, 1'b0, 32'h20, 32'd0, 0, 1'b0, rd, er, lat);
    chk("t1_store_dropped", 0, rd, 32'h11111111);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #2;
      reset_n = ($urandom_range(0, 249) != 0);
      for (int d = 0; d < 2; d++) begin
        req_valid[d] = 1'($urandom_range(0, 1));
        req_we[d]    = 1'($urandom_range(0, 1));
        req_addr[d]  = rnd_addr();
        req_wdata[d] = $urandom;
        rsp_ready[d] = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clock); #2;
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
    end
    repeat (4) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
